// File: rtl/block_emitter_pkg.sv
// Shared constants for the block keyword emitter: ASCII codes, op codes and FSM state encoding.
package block_pkg;

    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_B     = 8'h62;
    localparam logic [7:0] CH_E     = 8'h65;
    localparam logic [7:0] CH_G     = 8'h67;
    localparam logic [7:0] CH_I     = 8'h69;
    localparam logic [7:0] CH_N     = 8'h6E;
    localparam logic [7:0] CH_D     = 8'h64;
    localparam logic [7:0] CASE_OFS = 8'h20;

    localparam logic OP_BEGIN = 1'b0;
    localparam logic OP_END   = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_B_B  = 4'd1,
        ST_B_E  = 4'd2,
        ST_B_G  = 4'd3,
        ST_B_I  = 4'd4,
        ST_B_N  = 4'd5,
        ST_E_E  = 4'd6,
        ST_E_N  = 4'd7,
        ST_E_D  = 4'd8,
        ST_SP   = 4'd9
    } state_t;

    // Lowercase letter carried by each state; IDLE and SP both show a space.
    function automatic logic [7:0] state_letter(input state_t s);
        logic [7:0] c;
        c = CH_SP;
        case (s)
            ST_B_B:  c = CH_B;
            ST_B_E:  c = CH_E;
            ST_B_G:  c = CH_G;
            ST_B_I:  c = CH_I;
            ST_B_N:  c = CH_N;
            ST_E_E:  c = CH_E;
            ST_E_N:  c = CH_N;
            ST_E_D:  c = CH_D;
            default: c = CH_SP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/block_emitter_if.sv
// Command handshake, character stream and nesting status of the block emitter.
interface block_emitter_if #(
    parameter int DEPTH_W = 8
);
    logic               cmd_valid;
    logic               cmd_op;
    logic               cmd_upper;
    logic               cmd_ready;
    logic [7:0]         out_char;
    logic               out_valid;
    logic [DEPTH_W-1:0] depth;
    logic               balanced;
    logic               err_underflow;
    logic               err_overflow;

    modport master (
        output cmd_valid, cmd_op, cmd_upper,
        input  cmd_ready, out_char, out_valid, depth, balanced, err_underflow, err_overflow
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_upper,
        output cmd_ready, out_char, out_valid, depth, balanced, err_underflow, err_overflow
    );
endinterface

// File: rtl/block_emitter_depth_counter.sv
// Saturating nesting-depth counter with sticky overflow/underflow flags.
module block_depth_counter #(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_en,
    input  logic               i_inc,
    input  logic               i_dec,
    output logic [DEPTH_W-1:0] o_count,
    output logic               o_overflow,
    output logic               o_underflow
);
    localparam logic [DEPTH_W-1:0] MAX_COUNT = '1;

    logic [DEPTH_W-1:0] r_count;
    logic               r_overflow;
    logic               r_underflow;

    // At a limit the count holds and only the matching flag is raised.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_en) begin
            if (i_inc) begin
                if (r_count == MAX_COUNT) r_overflow <= 1'b1;
                else                      r_count    <= r_count + 1'b1;
            end else if (i_dec) begin
                if (r_count == '0) r_underflow <= 1'b1;
                else               r_count     <= r_count - 1'b1;
            end
        end
    end

    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: rtl/block_emitter.sv
// Emits "begin "/"end " one character per clock from a command handshake and
// tracks the nesting verdict a downstream block checker will reach.
module block_emitter
    import block_pkg::*;
#(
    parameter int DEPTH_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    block_emitter_if.slave bus
);
    state_t             r_state;
    state_t             w_state_next;
    logic               r_op;
    logic               r_upper;
    logic               w_ready;
    logic               w_accept;
    logic               w_out_valid;
    logic [7:0]         w_letter;
    logic               w_cnt_en;
    logic [DEPTH_W-1:0] w_depth;
    logic               w_overflow;
    logic               w_underflow;

    assign w_accept = bus.cmd_valid && w_ready;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_out_valid  = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_ready     = 1'b1;
                w_out_valid = 1'b0;
                if (w_accept) w_state_next = (bus.cmd_op == OP_END) ? ST_E_E : ST_B_B;
            end
            ST_B_B: w_state_next = ST_B_E;
            ST_B_E: w_state_next = ST_B_G;
            ST_B_G: w_state_next = ST_B_I;
            ST_B_I: w_state_next = ST_B_N;
            ST_B_N: w_state_next = ST_SP;
            ST_E_E: w_state_next = ST_E_N;
            ST_E_N: w_state_next = ST_E_D;
            ST_E_D: w_state_next = ST_SP;
            ST_SP: begin
                // A command waiting here starts its word with no idle gap.
                w_ready = 1'b1;
                if (w_accept) w_state_next = (bus.cmd_op == OP_END) ? ST_E_E : ST_B_B;
                else          w_state_next = ST_IDLE;
            end
            default: begin
                w_out_valid  = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= OP_BEGIN;
            r_upper <= 1'b0;
        end else if (w_accept) begin
            r_op    <= bus.cmd_op;
            r_upper <= bus.cmd_upper;
        end
    end

    assign w_letter = state_letter(r_state);

    // The counter sees the op of the word ending now; a new op latched on
    // the same edge only affects the next word.
    assign w_cnt_en = (r_state == ST_SP);

    block_depth_counter #(
        .DEPTH_W (DEPTH_W)
    ) u_depth (
        .clk         (clk),
        .reset       (reset),
        .i_en        (w_cnt_en),
        .i_inc       (r_op == OP_BEGIN),
        .i_dec       (r_op == OP_END),
        .o_count     (w_depth),
        .o_overflow  (w_overflow),
        .o_underflow (w_underflow)
    );

    assign bus.cmd_ready     = w_ready;
    assign bus.out_valid     = w_out_valid;
    assign bus.out_char      = (r_upper && (w_letter != CH_SP)) ? (w_letter - CASE_OFS) : w_letter;
    assign bus.depth         = w_depth;
    assign bus.balanced      = (w_depth == '0) && !w_underflow;
    assign bus.err_underflow = w_underflow;
    assign bus.err_overflow  = w_overflow;

endmodule

// File: tb/tb_block_emitter.sv
// Bench for block_emitter: a word-queue model checked every cycle against two DUTs
// (8-bit and 2-bit depth) sharing one command stream, plus directed literal checks.
module tb_block_emitter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cmd_valid = 1'b0;
    logic cmd_op = 1'b0;
    logic cmd_upper = 1'b0;

    always #5 clk = ~clk;

    block_emitter_if #(.DEPTH_W(8)) bus8 ();
    block_emitter_if #(.DEPTH_W(2)) bus2 ();

    assign bus8.cmd_valid = cmd_valid;
    assign bus8.cmd_op    = cmd_op;
    assign bus8.cmd_upper = cmd_upper;
    assign bus2.cmd_valid = cmd_valid;
    assign bus2.cmd_op    = cmd_op;
    assign bus2.cmd_upper = cmd_upper;

    block_emitter #(.DEPTH_W(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));
    block_emitter #(.DEPTH_W(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the current word is a queue of characters still to emit.
    logic [7:0] m_q[$];
    logic [7:0] m_cur = 8'h20;
    logic       m_valid = 1'b0;
    logic       m_ready = 1'b1;
    logic       m_op = 1'b0;
    logic       m_acc = 1'b0;
    int         m_depth8 = 0, m_depth2 = 0;
    logic       m_ovf8 = 0, m_unf8 = 0, m_ovf2 = 0, m_unf2 = 0;
    logic       started = 1'b0;
    int         epoch = 0;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_acc = 0; m_q.delete(); m_cur = 8'h20; m_valid = 0; m_ready = 1;
            m_depth8 = 0; m_depth2 = 0; m_ovf8 = 0; m_unf8 = 0; m_ovf2 = 0; m_unf2 = 0;
            started = 1; epoch++;
        end else begin
            m_acc = cmd_valid && m_ready;
            if (m_valid && m_q.size() == 0) begin
                if (m_op == 1'b0) begin
                    if (m_depth8 < 255) m_depth8++; else m_ovf8 = 1;
                    if (m_depth2 < 3)   m_depth2++; else m_ovf2 = 1;
                end else begin
                    if (m_depth8 > 0) m_depth8--; else m_unf8 = 1;
                    if (m_depth2 > 0) m_depth2--; else m_unf2 = 1;
                end
            end
            if (m_acc) begin
                string s;
                s = cmd_op ? "end " : "begin ";
                m_op = cmd_op;
                m_q.delete();
                for (int i = 0; i < s.len(); i++) begin
                    logic [7:0] c;
                    c = s[i];
                    if (cmd_upper && c != 8'h20) c = c - 8'h20;
                    m_q.push_back(c);
                end
                m_cur = m_q.pop_front();
                m_valid = 1;
            end else if (m_q.size() != 0) begin
                m_cur = m_q.pop_front();
            end else begin
                m_valid = 0;
                m_cur = 8'h20;
            end
            m_ready = !m_valid || (m_q.size() == 0);
        end
    end

    // Per-cycle compare, DUT character log and a word-level checker over the stream.
    logic [7:0] log_q[$];
    int         seen_epoch = 0;
    int         chk_depth = 0;
    logic       chk_unf = 0;
    int         wlen = 0;
    logic [7:0] wfirst = 8'h00;

    initial forever begin
        @(negedge clk);
        if (started) begin
            if (epoch != seen_epoch) begin
                seen_epoch = epoch;
                log_q.delete();
                chk_depth = 0; chk_unf = 0; wlen = 0;
            end
            check("out_char8",  32'(bus8.out_char), 32'(m_cur));
            check("out_char2",  32'(bus2.out_char), 32'(m_cur));
            check("out_valid8", 32'(bus8.out_valid), 32'(m_valid));
            check("cmd_ready8", 32'(bus8.cmd_ready), 32'(m_ready));
            check("cmd_ready2", 32'(bus2.cmd_ready), 32'(m_ready));
            check("depth8",     32'(bus8.depth), m_depth8);
            check("depth2",     32'(bus2.depth), m_depth2);
            check("balanced8",  32'(bus8.balanced), 32'(m_depth8 == 0 && !m_unf8));
            check("balanced2",  32'(bus2.balanced), 32'(m_depth2 == 0 && !m_unf2));
            check("unf8",       32'(bus8.err_underflow), 32'(m_unf8));
            check("ovf8",       32'(bus8.err_overflow), 32'(m_ovf8));
            check("unf2",       32'(bus2.err_underflow), 32'(m_unf2));
            check("ovf2",       32'(bus2.err_overflow), 32'(m_ovf2));
            if (bus8.out_valid) begin
                log_q.push_back(bus8.out_char);
                if (bus8.out_char == 8'h20) begin
                    if ((wfirst | 8'h20) == 8'h62 && wlen == 5) chk_depth++;
                    else if ((wfirst | 8'h20) == 8'h65 && wlen == 3) begin
                        if (chk_depth > 0) chk_depth--; else chk_unf = 1;
                    end
                    wlen = 0;
                end else begin
                    if (wlen == 0) wfirst = bus8.out_char;
                    wlen++;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1; cmd_valid = 0;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic send(input logic op, input logic up);
        @(negedge clk);
        cmd_valid = 1; cmd_op = op; cmd_upper = up;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (m_acc) return;
        end
        check("send_timeout", 32'd1, 32'd0);
        cmd_valid = 0;
    endtask

    task automatic wait_idle();
        @(negedge clk);
        cmd_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (!m_valid) return;
        end
        check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_log(input string name, input int start, input string exp);
        check({name, "_len"}, log_q.size() - start, exp.len());
        for (int i = 0; i < exp.len() && (start + i) < log_q.size(); i++)
            check(name, 32'(log_q[start + i]), 32'(exp[i]));
    endtask

    initial begin
        int start;
        // 1: reset state and a balanced begin/end pair back to back
        do_reset();
        check("rst_char",  32'(bus8.out_char), 32'h20);
        check("rst_valid", 32'(bus8.out_valid), 32'd0);
        check("rst_ready", 32'(bus8.cmd_ready), 32'd1);
        check("rst_depth", 32'(bus8.depth), 32'd0);
        check("rst_bal",   32'(bus8.balanced), 32'd1);
        start = log_q.size();
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        check("t1_depth_mid", 32'(bus8.depth), 32'd1);
        wait_idle();
        check_log("t1_log", start, "begin end ");
        check("t1_depth", 32'(bus8.depth), 32'd0);
        check("t1_bal",   32'(bus8.balanced), 32'd1);

        // 2: underflow is sticky and keeps balanced low
        do_reset();
        start = log_q.size();
        send(1'b1, 1'b0);
        wait_idle();
        check_log("t2_log", start, "end ");
        check("t2_unf", 32'(bus8.err_underflow), 32'd1);
        check("t2_bal", 32'(bus8.balanced), 32'd0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        wait_idle();
        check("t2_depth", 32'(bus8.depth), 32'd0);
        check("t2_bal2",  32'(bus8.balanced), 32'd0);
        check("t2_loop",  32'(bus8.balanced), 32'(chk_depth == 0 && !chk_unf));

        // 3: uppercase begin followed by lowercase end
        do_reset();
        start = log_q.size();
        send(1'b0, 1'b1);
        send(1'b1, 1'b0);
        wait_idle();
        check_log("t3_log", start, "BEGIN end ");

        // 4: reset in the middle of a word aborts it
        do_reset();
        send(1'b0, 1'b0);
        @(negedge clk); cmd_valid = 0;
        @(negedge clk);
        @(negedge clk); reset = 1;
        @(negedge clk);
        check("t4_valid", 32'(bus8.out_valid), 32'd0);
        check("t4_char",  32'(bus8.out_char), 32'h20);
        check("t4_depth", 32'(bus8.depth), 32'd0);
        check("t4_ready", 32'(bus8.cmd_ready), 32'd1);
        reset = 0;

        // 5: 2-bit depth saturates at 3 and flags overflow on the 4th begin
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            send(1'b0, 1'b0);
            wait_idle();
            check("t5_depth2", 32'(bus2.depth), (i < 3) ? i : 3);
            check("t5_ovf2",   32'(bus2.err_overflow), 32'(i == 4));
            check("t5_depth8", 32'(bus8.depth), i);
        end

        // 6: random commands held until accepted, gaps, case mixing
        do_reset();
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                cmd_valid = 0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            send(($urandom_range(0, 99) < 55) ? 1'b0 : 1'b1, 1'($urandom_range(0, 1)));
        end
        wait_idle();
        check("t6_loop", 32'(bus8.balanced), 32'(chk_depth == 0 && !chk_unf));
        check("t6_depth_loop", 32'(bus8.depth), chk_depth);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
